// File: rtl/dip_serial_pkg.sv
// Shared types and helpers for the DIP/switch serial capture block:
// FSM state encoding, a ceil-log2 helper and the word assembly function
// (bit order selection followed by optional byte swap).
package dip_serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } state_t;

    // Ceil-log2 with a floor of 1 so a counter is never zero bits wide.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // raw[i] holds the i-th bit sampled from the chain. With msb_first the
    // first sampled bit lands on the top bit of the word. Byte swap then
    // exchanges the two bytes inside every 16-bit lane.
    function automatic logic [63:0] assemble_word(input logic [63:0] raw,
                                                  input int width,
                                                  input logic msb_first,
                                                  input logic byte_swap);
        logic [63:0] ordered;
        logic [63:0] swapped;
        ordered = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < width) begin
                if (msb_first) begin
                    ordered[width - 1 - i] = raw[i];
                end else begin
                    ordered[i] = raw[i];
                end
            end
        end
        swapped = ordered;
        if (byte_swap) begin
            for (int k = 0; k < 4; k++) begin
                if ((16 * k + 15) < width) begin
                    swapped[16 * k +: 8]     = ordered[16 * k + 8 +: 8];
                    swapped[16 * k + 8 +: 8] = ordered[16 * k +: 8];
                end
            end
        end
        return swapped;
    endfunction

endpackage

// File: rtl/dip_tick_gen.sv
// Serial tick prescaler: one tick every CLK_DIV enabled cycles.
// clr has priority and holds the count at zero so each phase starts aligned.
module dip_tick_gen
    import dip_serial_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    assign tick = en && !clr && (cnt == CW'(CLK_DIV - 1));

    // Count enabled cycles, wrapping on the tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/dip_serial_capture.sv
// Drives a 74HC165-style parallel-in/serial-out chain: pulses the latch,
// clocks WIDTH bits in, then publishes the assembled word with a valid
// pulse and a changed flag.
// Optional macro DIP_SERIAL_CAPTURE_DEBOUNCE_EN: publish only after
// DEB_FRAMES consecutive identical frames that differ from o_DATA.
module dip_serial_capture
    import dip_serial_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int CLK_DIV    = 4,
    parameter int MSB_FIRST  = 1,
    parameter int BYTE_SWAP  = 0,
    parameter int DEB_FRAMES = 3
) (
    input  logic             i_CLK,
    input  logic             i_RESET_n,
    input  logic             i_START,
    input  logic             i_CONT,
    input  logic             i_SDATA,
    output logic             o_SCLK,
    output logic             o_LATCH_n,
    output logic [WIDTH-1:0] o_DATA,
    output logic             o_VALID,
    output logic             o_CHANGED,
    output logic             o_BUSY
);

    localparam int BW = clog2(WIDTH);

    state_t           state;
    logic [BW-1:0]    bitcnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] word;
    logic             tick;
    logic             tick_clr;
    logic             publish;

    // Prescaler idles in IDLE and restarts from zero in DONE, so every
    // LOAD phase lasts a full CLK_DIV cycles, including back-to-back frames.
    assign tick_clr = (state == IDLE) || (state == DONE);

    dip_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clk  (i_CLK),
        .rst_n(i_RESET_n),
        .en   (state != IDLE),
        .clr  (tick_clr),
        .tick (tick)
    );

    assign o_BUSY = (state != IDLE);

    // Apply the configured bit order and byte swap to the sampled bits.
    always_comb begin
        word = WIDTH'(assemble_word(64'(shreg), WIDTH, (MSB_FIRST != 0), (BYTE_SWAP != 0)));
    end

`ifdef DIP_SERIAL_CAPTURE_DEBOUNCE_EN
    logic [3:0]       match_cnt;
    logic [3:0]       match_next;
    logic [WIDTH-1:0] prev_word;

    // Run length of identical frames, saturating at DEB_FRAMES.
    always_comb begin
        match_next = 4'd1;
        if (word == prev_word) begin
            match_next = (match_cnt >= 4'(DEB_FRAMES)) ? 4'(DEB_FRAMES) : match_cnt + 4'd1;
        end
    end

    assign publish = (state == DONE) && (match_next == 4'(DEB_FRAMES)) && (word != o_DATA);

    // Remember the last assembled word and its run length.
    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            match_cnt <= '0;
            prev_word <= '0;
        end else if (state == DONE) begin
            match_cnt <= match_next;
            prev_word <= word;
        end
    end
`else
    logic unused_deb_frames;
    assign unused_deb_frames = (DEB_FRAMES != 0);
    assign publish = (state == DONE);
`endif

    // Frame sequencer with registered chain strobes and publish outputs.
    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            state     <= IDLE;
            bitcnt    <= '0;
            shreg     <= '0;
            o_SCLK    <= 1'b0;
            o_LATCH_n <= 1'b1;
            o_DATA    <= '0;
            o_VALID   <= 1'b0;
            o_CHANGED <= 1'b0;
        end else begin
            o_VALID   <= 1'b0;
            o_CHANGED <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_START || i_CONT) begin
                        state     <= LOAD;
                        o_LATCH_n <= 1'b0;
                    end
                end
                LOAD: begin
                    if (tick) begin
                        state     <= SHIFT_LO;
                        o_LATCH_n <= 1'b1;
                        bitcnt    <= '0;
                    end
                end
                SHIFT_LO: begin
                    if (tick) begin
                        shreg[bitcnt] <= i_SDATA;
                        state         <= SHIFT_HI;
                        o_SCLK        <= 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (tick) begin
                        o_SCLK <= 1'b0;
                        if (bitcnt == BW'(WIDTH - 1)) begin
                            state <= DONE;
                        end else begin
                            bitcnt <= bitcnt + BW'(1);
                            state  <= SHIFT_LO;
                        end
                    end
                end
                DONE: begin
                    if (publish) begin
                        o_DATA    <= word;
                        o_VALID   <= 1'b1;
                        o_CHANGED <= (word != o_DATA);
                    end
                    if (i_CONT) begin
                        state     <= LOAD;
                        o_LATCH_n <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dip_serial_capture.sv
// Bench for dip_serial_capture: three 16-bit instances (MSB-first,
// LSB-first, byte-swapped) share one chain model and control inputs;
// a fourth 8-bit CLK_DIV=1 instance has its own chain model.
`timescale 1ns/1ps
module tb_dip_serial_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, cont, start_f, cont_f;

    logic        sclk_m, latch_m, valid_m, chg_m, busy_m;
    logic [15:0] data_m;
    logic        sclk_l, latch_l, valid_l, chg_l, busy_l;
    logic [15:0] data_l;
    logic        sclk_s, latch_s, valid_s, chg_s, busy_s;
    logic [15:0] data_s;
    logic        sclk_f, latch_f, valid_f, chg_f, busy_f;
    logic [7:0]  data_f;

    int n_vec  = 0;
    int n_fail = 0;

    // 74HC165 model for the 16-bit instances: parallel load while latch is low,
    // shift toward QH on each rising serial clock.
    logic [15:0] chain_m = '0;
    logic [15:0] sr_m = '0;
    logic        sclk_prev_m = 1'b0;
    logic        sdata_m;
    always @(negedge clk) begin
        if (!latch_m) sr_m <= chain_m;
        else if (sclk_m && !sclk_prev_m) sr_m <= {sr_m[14:0], 1'b0};
        sclk_prev_m <= sclk_m;
    end
    assign sdata_m = sr_m[15];

    logic [7:0] chain_f = '0;
    logic [7:0] sr_f = '0;
    logic       sclk_prev_f = 1'b0;
    logic       sdata_f;
    always @(negedge clk) begin
        if (!latch_f) sr_f <= chain_f;
        else if (sclk_f && !sclk_prev_f) sr_f <= {sr_f[6:0], 1'b0};
        sclk_prev_f <= sclk_f;
    end
    assign sdata_f = sr_f[7];

    dip_serial_capture #(.WIDTH(16), .CLK_DIV(4), .MSB_FIRST(1), .BYTE_SWAP(0), .DEB_FRAMES(3)) dut_m (
        .i_CLK(clk), .i_RESET_n(rst_n), .i_START(start), .i_CONT(cont), .i_SDATA(sdata_m),
        .o_SCLK(sclk_m), .o_LATCH_n(latch_m), .o_DATA(data_m), .o_VALID(valid_m),
        .o_CHANGED(chg_m), .o_BUSY(busy_m));

    dip_serial_capture #(.WIDTH(16), .CLK_DIV(4), .MSB_FIRST(0), .BYTE_SWAP(0), .DEB_FRAMES(3)) dut_l (
        .i_CLK(clk), .i_RESET_n(rst_n), .i_START(start), .i_CONT(cont), .i_SDATA(sdata_m),
        .o_SCLK(sclk_l), .o_LATCH_n(latch_l), .o_DATA(data_l), .o_VALID(valid_l),
        .o_CHANGED(chg_l), .o_BUSY(busy_l));

    dip_serial_capture #(.WIDTH(16), .CLK_DIV(4), .MSB_FIRST(1), .BYTE_SWAP(1), .DEB_FRAMES(3)) dut_s (
        .i_CLK(clk), .i_RESET_n(rst_n), .i_START(start), .i_CONT(cont), .i_SDATA(sdata_m),
        .o_SCLK(sclk_s), .o_LATCH_n(latch_s), .o_DATA(data_s), .o_VALID(valid_s),
        .o_CHANGED(chg_s), .o_BUSY(busy_s));

    dip_serial_capture #(.WIDTH(8), .CLK_DIV(1), .MSB_FIRST(1), .BYTE_SWAP(0), .DEB_FRAMES(3)) dut_f (
        .i_CLK(clk), .i_RESET_n(rst_n), .i_START(start_f), .i_CONT(cont_f), .i_SDATA(sdata_f),
        .o_SCLK(sclk_f), .o_LATCH_n(latch_f), .o_DATA(data_f), .o_VALID(valid_f),
        .o_CHANGED(chg_f), .o_BUSY(busy_f));

    function automatic logic [15:0] bitrev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[15 - i] = v[i];
        return r;
    endfunction

    function automatic logic [15:0] swap16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    // Values captured on the valid pulse of the most recent run_frame.
    logic [15:0] cap_m, cap_l, cap_s;
    logic        cap_chg;

    // One i_START frame; returns latency (edges after the sampling edge) and valid count.
    task automatic run_frame(input logic [15:0] value, output int lat, output int nvalid);
        bit done;
        chain_m = value;
        @(negedge clk);
        start = 1'b1;
        lat = -1;
        nvalid = 0;
        done = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (valid_m) begin
                nvalid++;
                if (lat < 0) lat = c;
                cap_m = data_m; cap_l = data_l; cap_s = data_s; cap_chg = chg_m;
            end
            if (!busy_m) begin
                done = 1'b1;
                break;
            end
        end
        n_vec++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL frame_timeout: busy never dropped, done=%0b required 1", done); end
    endtask

    task automatic test_reset();
        int sclk_hi, latch_lo, busy_hi;
        rst_n = 1'b0; start = 1'b0; cont = 1'b0; start_f = 1'b0; cont_f = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (busy_m !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_m); end
        n_vec++; if (valid_m !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_m); end
        n_vec++; if (chg_m !== 1'b0) begin n_fail++; $display("FAIL reset_changed: got %b want 0", chg_m); end
        n_vec++; if (data_m !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", data_m); end
        n_vec++; if (sclk_m !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b want 0", sclk_m); end
        n_vec++; if (latch_m !== 1'b1) begin n_fail++; $display("FAIL reset_latch: got %b want 1", latch_m); end
        rst_n = 1'b1;
        sclk_hi = 0; latch_lo = 0; busy_hi = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (sclk_m) sclk_hi++;
            if (!latch_m) latch_lo++;
            if (busy_m) busy_hi++;
        end
        n_vec++; if (sclk_hi !== 0) begin n_fail++; $display("FAIL idle_sclk: %0d high cycles, want 0", sclk_hi); end
        n_vec++; if (latch_lo !== 0) begin n_fail++; $display("FAIL idle_latch: %0d low cycles, want 0", latch_lo); end
        n_vec++; if (busy_hi !== 0) begin n_fail++; $display("FAIL idle_busy: %0d busy cycles, want 0", busy_hi); end
    endtask

    task automatic test_single_frame();
        int lat, nv;
        run_frame(16'hA5C3, lat, nv);
        n_vec++; if (lat !== 133) begin n_fail++; $display("FAIL single_latency: got %0d want 133", lat); end
        n_vec++; if (nv !== 1) begin n_fail++; $display("FAIL single_valid_count: got %0d want 1", nv); end
        n_vec++; if (cap_m !== 16'hA5C3) begin n_fail++; $display("FAIL single_msb_data: got %h want a5c3", cap_m); end
        n_vec++; if (cap_l !== bitrev16(16'hA5C3)) begin n_fail++; $display("FAIL single_lsb_data: got %h want %h", cap_l, bitrev16(16'hA5C3)); end
        n_vec++; if (cap_s !== swap16(16'hA5C3)) begin n_fail++; $display("FAIL single_swap_data: got %h want %h", cap_s, swap16(16'hA5C3)); end
        n_vec++; if (cap_chg !== 1'b1) begin n_fail++; $display("FAIL single_changed: got %b want 1", cap_chg); end
        n_vec++; if (data_m !== 16'hA5C3) begin n_fail++; $display("FAIL single_data_hold: got %h want a5c3", data_m); end
    endtask

    task automatic test_clk_div1();
        int lat;
        logic [7:0] got;
        logic gchg;
        chain_f = 8'hB4;
        lat = -1; got = '0; gchg = 1'b0;
        @(negedge clk);
        start_f = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            start_f = 1'b0;
            if (valid_f) begin lat = c; got = data_f; gchg = chg_f; break; end
        end
        n_vec++; if (lat !== 18) begin n_fail++; $display("FAIL div1_latency: got %0d want 18", lat); end
        n_vec++; if (got !== 8'hB4) begin n_fail++; $display("FAIL div1_data: got %h want b4", got); end
        n_vec++; if (gchg !== 1'b1) begin n_fail++; $display("FAIL div1_changed: got %b want 1", gchg); end
    endtask

    task automatic test_continuous();
        int t[3];
        logic [15:0] d[3], dl[3], ds[3];
        logic chg[3];
        int frame, extra;
        frame = 0;
        for (int i = 0; i < 3; i++) begin t[i] = 0; d[i] = '0; dl[i] = '0; ds[i] = '0; chg[i] = 1'b0; end
        chain_m = 16'h00FF;
        @(negedge clk);
        cont = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (frame == 1 && c == t[0] + 20) chain_m = 16'h0100;
            if (frame == 2 && c == t[1] + 10) cont = 1'b0;
            if (valid_m && frame < 3) begin
                t[frame] = c; d[frame] = data_m; dl[frame] = data_l; ds[frame] = data_s; chg[frame] = chg_m;
                frame++;
            end
            if (frame == 3 && !busy_m) break;
        end
        cont = 1'b0;
        n_vec++; if (frame !== 3) begin n_fail++; $display("FAIL cont_frames: got %0d want 3", frame); end
        n_vec++; if (t[0] !== 133) begin n_fail++; $display("FAIL cont_first_latency: got %0d want 133", t[0]); end
        n_vec++; if (t[1] - t[0] !== 133) begin n_fail++; $display("FAIL cont_period1: got %0d want 133", t[1] - t[0]); end
        n_vec++; if (t[2] - t[1] !== 133) begin n_fail++; $display("FAIL cont_period2: got %0d want 133", t[2] - t[1]); end
        n_vec++; if (d[0] !== 16'h00FF || chg[0] !== 1'b1) begin n_fail++; $display("FAIL cont_f1: got %h/%b want 00ff/1", d[0], chg[0]); end
        n_vec++; if (d[1] !== 16'h00FF || chg[1] !== 1'b0) begin n_fail++; $display("FAIL cont_f2: got %h/%b want 00ff/0", d[1], chg[1]); end
        n_vec++; if (d[2] !== 16'h0100 || chg[2] !== 1'b1) begin n_fail++; $display("FAIL cont_f3: got %h/%b want 0100/1", d[2], chg[2]); end
        n_vec++; if (dl[2] !== bitrev16(16'h0100)) begin n_fail++; $display("FAIL cont_lsb: got %h want %h", dl[2], bitrev16(16'h0100)); end
        n_vec++; if (ds[2] !== swap16(16'h0100)) begin n_fail++; $display("FAIL cont_swap: got %h want %h", ds[2], swap16(16'h0100)); end
        extra = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (valid_m || busy_m) extra++;
        end
        n_vec++; if (extra !== 0) begin n_fail++; $display("FAIL cont_stop: %0d active cycles after cont drop, want 0", extra); end
    endtask

    task automatic test_reset_mid_frame();
        int nv, lat;
        logic sclk_before;
        chain_m = 16'h5A3C;
        sclk_before = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c <= 65; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        sclk_before = sclk_m;
        rst_n = 1'b0;
        #1;
        n_vec++; if (sclk_before !== 1'b1) begin n_fail++; $display("FAIL midrst_in_shift_hi: sclk %b want 1", sclk_before); end
        n_vec++; if (busy_m !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy_m); end
        n_vec++; if (sclk_m !== 1'b0) begin n_fail++; $display("FAIL midrst_sclk: got %b want 0", sclk_m); end
        n_vec++; if (latch_m !== 1'b1) begin n_fail++; $display("FAIL midrst_latch: got %b want 1", latch_m); end
        n_vec++; if (data_m !== 16'h0000) begin n_fail++; $display("FAIL midrst_data: got %h want 0000", data_m); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (valid_m) nv++;
        end
        n_vec++; if (nv !== 0) begin n_fail++; $display("FAIL midrst_no_publish: %0d valids want 0", nv); end
        run_frame(16'h5A3C, lat, nv);
        n_vec++; if (lat !== 133 || nv !== 1) begin n_fail++; $display("FAIL restart_frame: lat %0d nv %0d want 133/1", lat, nv); end
        n_vec++; if (cap_m !== 16'h5A3C || cap_chg !== 1'b1) begin n_fail++; $display("FAIL restart_data: got %h/%b want 5a3c/1", cap_m, cap_chg); end
        n_vec++; if (cap_l !== bitrev16(16'h5A3C)) begin n_fail++; $display("FAIL restart_lsb: got %h want %h", cap_l, bitrev16(16'h5A3C)); end
    endtask

    task automatic test_start_while_busy();
        int nv;
        chain_m = 16'h1357;
        nv = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            start = (c == 50 || c == 132) ? 1'b1 : 1'b0;
            if (valid_m) nv++;
        end
        start = 1'b0;
        n_vec++; if (nv !== 1) begin n_fail++; $display("FAIL busy_start_valids: got %0d want 1", nv); end
        n_vec++; if (data_m !== 16'h1357) begin n_fail++; $display("FAIL busy_start_data: got %h want 1357", data_m); end
        n_vec++; if (busy_m !== 1'b0) begin n_fail++; $display("FAIL busy_start_idle: got %b want 0", busy_m); end
    endtask

    task automatic test_debounce();
        logic [15:0] seq[5];
        int lat, nv;
        seq[0] = 16'h1234; seq[1] = 16'h1234; seq[2] = 16'h1235; seq[3] = 16'h1235; seq[4] = 16'h1235;
        for (int i = 0; i < 5; i++) begin
            run_frame(seq[i], lat, nv);
            n_vec++;
            if (nv !== ((i == 4) ? 1 : 0)) begin n_fail++; $display("FAIL deb_frame%0d_valids: got %0d want %0d", i, nv, (i == 4) ? 1 : 0); end
        end
        n_vec++; if (cap_m !== 16'h1235) begin n_fail++; $display("FAIL deb_data: got %h want 1235", cap_m); end
        n_vec++; if (cap_chg !== 1'b1) begin n_fail++; $display("FAIL deb_changed: got %b want 1", cap_chg); end
        n_vec++; if (cap_l !== bitrev16(16'h1235)) begin n_fail++; $display("FAIL deb_lsb: got %h want %h", cap_l, bitrev16(16'h1235)); end
        n_vec++; if (lat !== 133) begin n_fail++; $display("FAIL deb_latency: got %0d want 133", lat); end
    endtask

    initial begin
        test_reset();
`ifdef DIP_SERIAL_CAPTURE_DEBOUNCE_EN
        test_debounce();
`else
        test_single_frame();
        test_clk_div1();
        test_continuous();
        test_reset_mid_frame();
        test_start_while_busy();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/dip_serial_capture.md
Name: dip_serial_capture

Overview:
- Parametrised successor to the fixed 16-bit DIP parallelizer.
- Drives an external parallel-in/serial-out shift-register chain (74HC165-style): generates the latch strobe and the serial clock itself, then shifts in WIDTH bits.
- Publishes the captured word with a valid pulse and a change flag.
- Sits between the board DIP/switch chain and the CPU I/O register file.

Parameters:
- WIDTH, 16: number of bits in the chain; legal range 2..64.
- CLK_DIV, 4: i_CLK cycles per serial tick (one half-period of o_SCLK); legal range 1..1024.
- MSB_FIRST, 1: 1 = first sampled bit goes to o_DATA[WIDTH-1]; 0 = first sampled bit goes to o_DATA[0].
- BYTE_SWAP, 0: 1 = swap byte halves of the assembled word before publishing. Legal only when WIDTH is a multiple of 16.
- DEB_FRAMES, 3: consecutive identical frames needed before publishing. Used only with DEBOUNCE_EN; legal range 2..15.

Ports:
- i_CLK  in  1  system clock; all logic on posedge.
- i_RESET_n  in  1  asynchronous, active-low reset.
- i_START  in  1  one-cycle request for a single frame; sampled only in IDLE.
- i_CONT  in  1  1 = restart automatically after every frame.
- i_SDATA  in  1  serial data from the chain.
- o_SCLK  out  1  serial clock to the chain.
- o_LATCH_n  out  1  parallel-load strobe to the chain, active low.
- o_DATA  out  WIDTH  last published word.
- o_VALID  out  1  one-cycle pulse when o_DATA is updated.
- o_CHANGED  out  1  high together with o_VALID when the new word differs from the previous o_DATA.
- o_BUSY  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, while i_RESET_n=0):
  - state=IDLE; o_DATA=0, o_VALID=0, o_CHANGED=0, o_BUSY=0.
  - o_SCLK=0, o_LATCH_n=1.
  - Tick counter, bit counter and shift register all cleared.
- Tick generator: a counter of width clog2(CLK_DIV) runs only outside IDLE. A tick asserts every CLK_DIV cycles. With CLK_DIV=1, a tick asserts every cycle.
- FSM states: IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE.
  - IDLE: when i_START or i_CONT is 1, go to LOAD next cycle and clear the tick counter.
  - LOAD: o_LATCH_n=0 for exactly one tick, then SHIFT_LO with bit counter=0.
  - SHIFT_LO: o_SCLK=0. On the tick, sample i_SDATA into the shift register at position bitcnt, then go to SHIFT_HI.
  - SHIFT_HI: o_SCLK=1. On the tick, increment bitcnt. If bitcnt reaches WIDTH-1, go to DONE; otherwise go to SHIFT_LO.
  - DONE: lasts one i_CLK cycle. Assemble the word (apply MSB_FIRST, then BYTE_SWAP) and publish it. o_SCLK=0.
    - If i_CONT=1, go to LOAD; otherwise go to IDLE.
- Frame length: CLK_DIV×(1+2×WIDTH)+1 cycles from leaving IDLE to o_VALID.
- Publish: o_DATA updates on the DONE cycle; o_VALID and o_CHANGED are registered and high in the following cycle.
- Start handling:
  - i_START asserted while busy is ignored; requests are not queued.
  - i_CONT dropping mid-frame completes the current frame, then the FSM returns to IDLE.
- Output registering: o_SCLK and o_LATCH_n are registered and glitch-free. Neither toggles in IDLE.
- Reset mid-frame: abort immediately to reset values. A partial word is never published.
- Bit counter width is clog2(WIDTH). No wrap is possible because the DONE exit precedes it.

Optional Feature:
- Macro: DIP_SERIAL_CAPTURE_DEBOUNCE_EN.
- Defined:
  - Each assembled word is compared with the previous assembled word, and a 4-bit match counter tracks consecutive identical frames.
  - The counter increments on a match (saturating at DEB_FRAMES); it resets to 1 on a mismatch.
  - o_DATA, o_VALID and o_CHANGED update only when the counter equals DEB_FRAMES and the word differs from o_DATA.
  - The first publish after reset also requires DEB_FRAMES identical frames.
  - Reset clears the counter and the previous-word register.
- Undefined: every DONE publishes, and the DEB_FRAMES parameter is ignored.

Decomposition:
- Package dip_serial_pkg:
  - FSM state enum (IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE).
  - Function for bit-order/byte-swap assembly.
  - clog2 helper.
- Sub-module dip_tick_gen: CLK_DIV prescaler with enable and clear, output tick.
- FSM, shift register and debounce stay in the top level.

Test Plan:
- Single frame, WIDTH=16, CLK_DIV=4, MSB_FIRST=1, chain=0xA5C3; pulse i_START → o_VALID at cycle 4×33+1=133 after start, o_DATA=0xA5C3, o_CHANGED=1.
- LSB-first order, MSB_FIRST=0, same chain → o_DATA=0xC3A5 bit-reversed, i.e. 0xC3A5 reversed=0xA5C3→0xC3A5 check against the bit-reverse model; BYTE_SWAP=1 with MSB_FIRST=1 → 0xC3A5.
- Continuous mode: i_CONT=1, chain constant 0x00FF → one o_VALID per frame; o_CHANGED=1 on the first frame only. Change the chain to 0x0100 → o_CHANGED=1 on the next frame.
- Reset mid-frame: assert i_RESET_n=0 during SHIFT_HI of bit 7 → outputs immediately at reset values, no o_VALID. Restart → full correct frame.
- i_START asserted while o_BUSY=1 → ignored; exactly one frame and one o_VALID.
- DEBOUNCE_EN, DEB_FRAMES=3: chain 0x1234, 0x1234, 0x1235, 0x1235, 0x1235 → single publish, of 0x1235, after the fifth frame.
